// File: rtl/softmax_normalizer.sv
// Softmax normalizer: final stage of the softmax pipeline.
// Buffers one vector of float32 exponentials, captures the float32 reciprocal
// of their sum, then streams out exp(x_i) * (1/sum) in arrival order.
//
// Ports:
//   clk, areset             clock and asynchronous active-high reset
//   in_valid/in_ready       element handshake; in_data float32, in_last ends vector
//   recip_valid/recip_data  one-cycle pulse carrying float32 1/sum
//   out_valid/out_ready     result handshake; out_data float32, out_last ends vector
//   err_len                 sticky: vector reached DEPTH elements without in_last
//   err_recip               sticky: reciprocal pulse arrived while draining
module softmax_normalizer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        recip_valid,
  input  logic [31:0] recip_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        err_len,
  output logic        err_recip
);

  typedef enum logic [1:0] {StFill, StWaitRecip, StDrain} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   rd_ptr_q, count_q;
  logic [31:0]   recip_q;
  logic          recip_held_q;
  logic          out_valid_q, out_last_q;
  logic [31:0]   out_data_q;
  logic          err_len_q, err_recip_q;
  logic          accept, issue, last_done;
  logic [31:0]   prod;

  // float32 multiply: denormals flush to zero, RNE rounding, no denormal results.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rnd;
    logic [47:0]        p;
    logic [22:0]        m;
    logic [23:0]        mr;
    logic               g, st;
    logic signed [9:0]  e;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    p      = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    rnd = g && (st || m[0]);
    mr  = {1'b0, m} + {23'd0, rnd};
    // Carry out of rounding leaves an all-zero fraction; only the exponent moves.
    if (mr[23]) e = e + 10'sd1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      fmul = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      fmul = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      fmul = {s, 31'd0};
    end else if (e >= 10'sd255) begin
      fmul = {s, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      fmul = {s, 31'd0};
    end else begin
      fmul = {s, e[7:0], mr[22:0]};
    end
  endfunction

  assign prod = fmul(mem_q[rd_ptr_q[AW-1:0]], recip_q);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    last_done = 1'b0;
    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && (in_last || wr_ptr_q == LastAddr)) state_d = StWaitRecip;
      end
      StWaitRecip: begin
        if (recip_held_q || recip_valid) state_d = StDrain;
      end
      StDrain: begin
        issue     = (rd_ptr_q < count_q) && (!out_valid_q || out_ready);
        last_done = out_valid_q && out_ready && out_last_q;
        if (last_done) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= StFill;
    else        state_q <= state_d;
  end

  // Buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      recip_q      <= '0;
      recip_held_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      err_len_q    <= 1'b0;
      err_recip_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (state_d == StWaitRecip) begin
          count_q <= {1'b0, wr_ptr_q} + (AW + 1)'(1);
          // Closing without in_last can only mean the buffer filled up.
          if (!in_last) err_len_q <= 1'b1;
        end
      end
      if (recip_valid) begin
        if (state_q == StDrain) begin
          err_recip_q <= 1'b1;
        end else begin
          recip_q      <= recip_data;
          recip_held_q <= 1'b1;
        end
      end
      if (issue) begin
        out_data_q  <= prod;
        out_last_q  <= (rd_ptr_q == count_q - (AW + 1)'(1));
        out_valid_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + (AW + 1)'(1);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (last_done) begin
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        recip_held_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_len   = err_len_q;
  assign err_recip = err_recip_q;

endmodule
